usb_bulk_in_fifo: RTL and testbench



---
 rtl/usb_bulk_in_pkg.sv | 14 +
 rtl/usb_bulk_in_ram.sv | 25 ++
 rtl/usb_bulk_in_fifo.sv | 218 +++++++++++++++++++++
 tb/tb_usb_bulk_in_fifo.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/usb_bulk_in_pkg.sv
// Shared types and constants for the USB bulk-IN packet buffer.
package usb_bulk_in_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_FETCH    = 2'd1,
    ST_STREAM   = 2'd2,
    ST_WAIT_HSK = 2'd3
  } rd_state_e;

  localparam int END_BIT = 8;
  localparam int MEM_W   = 9;

endpackage

// File: rtl/usb_bulk_in_ram.sv
// Simple dual-port RAM: one write port, one registered read port (1-cycle latency).
module usb_bulk_in_ram #(
  parameter int AW = 11,
  parameter int DW = 9
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [2**AW];
  logic [DW-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/usb_bulk_in_fifo.sv
// Bulk-IN packet buffer: segments an AXI byte stream into USB packets and
// replays each packet until the host ACKs it.
module usb_bulk_in_fifo
  import usb_bulk_in_pkg::*;
#(
  parameter int ADDR_WIDTH      = 11,
  parameter int MAX_PACKET_SIZE = 512
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_tvalid_i,
  output logic                  s_tready_o,
  input  logic                  s_tlast_i,
  input  logic [7:0]            s_tdata_i,
  input  logic                  blk_in_xfer_i,
  input  logic                  blk_in_ack_i,
  output logic                  bid_has_data_o,
  output logic                  bid_tvalid_o,
  input  logic                  bid_tready_i,
  output logic                  bid_tlast_o,
  output logic [7:0]            bid_tdata_o,
  output logic [ADDR_WIDTH:0]   level_o,
  output logic [ADDR_WIDTH:0]   pkt_count_o
);

  localparam int PW = ADDR_WIDTH + 1;
  localparam logic [PW-1:0] DEPTH    = PW'(2**ADDR_WIDTH);
  localparam logic [PW-1:0] SEG_LAST = PW'(MAX_PACKET_SIZE - 1);

  rd_state_e state_q, state_d;

  logic [PW-1:0] wr_ptr_q, wr_ptr_d, seg_cnt_q, seg_cnt_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d, cm_ptr_q, cm_ptr_d;
  logic [PW-1:0] fa_ptr_q, fa_ptr_d, mark_q, mark_d;
  logic [PW-1:0] pkt_cnt_q, pkt_cnt_d, level;
  logic          has_data_q, xfer_q, ack_seen_q, ack_seen_d;
  logic          ov_q, ov_d, sv_q, sv_d, inf_q, inf_d;
  logic [MEM_W-1:0] od_q, od_d, sd_q, sd_d, ram_rdata;

  logic                  wr_en, seg_end, wr_end, commit, pop, issue, ram_re;
  logic [ADDR_WIDTH-1:0] ram_raddr;
  logic [1:0]            occ;

  // Write side
  assign level      = wr_ptr_q - cm_ptr_q;
  assign s_tready_o = (level != DEPTH);
  assign wr_en      = s_tvalid_i & s_tready_o;
  assign seg_end    = s_tlast_i | (seg_cnt_q == SEG_LAST);
  assign wr_end     = wr_en & seg_end;

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    seg_cnt_d = seg_cnt_q;
    if (wr_en) begin
      wr_ptr_d  = wr_ptr_q + 1'b1;
      seg_cnt_d = seg_end ? '0 : seg_cnt_q + 1'b1;
    end
  end

  always_comb begin
    pkt_cnt_d = pkt_cnt_q;
    case ({wr_end, commit})
      2'b10:   pkt_cnt_d = pkt_cnt_q + 1'b1;
      2'b01:   pkt_cnt_d = pkt_cnt_q - 1'b1;
      default: pkt_cnt_d = pkt_cnt_q;
    endcase
  end

  usb_bulk_in_ram #(.AW(ADDR_WIDTH), .DW(MEM_W)) u_ram (
    .clk     (clk),
    .we_i    (wr_en),
    .waddr_i (wr_ptr_q[ADDR_WIDTH-1:0]),
    .wdata_i ({seg_end, s_tdata_i}),
    .re_i    (ram_re),
    .raddr_i (ram_raddr),
    .rdata_o (ram_rdata)
  );

  // Output register + skid + one in-flight RAM read never exceed two bytes.
  assign pop   = ov_q & bid_tready_i;
  assign occ   = {1'b0, ov_q} + {1'b0, sv_q} + {1'b0, inf_q};
  assign issue = (occ - {1'b0, pop}) < 2'd2;

  always_comb begin
    state_d    = state_q;
    rd_ptr_d   = rd_ptr_q;
    cm_ptr_d   = cm_ptr_q;
    fa_ptr_d   = fa_ptr_q;
    mark_d     = mark_q;
    ack_seen_d = ack_seen_q;
    ov_d       = ov_q;
    sv_d       = sv_q;
    inf_d      = 1'b0;
    od_d       = od_q;
    sd_d       = sd_q;
    commit     = 1'b0;
    ram_re     = 1'b0;
    ram_raddr  = fa_ptr_q[ADDR_WIDTH-1:0];
    case (state_q)
      ST_IDLE: begin
        if (blk_in_xfer_i && !xfer_q && (pkt_cnt_q != '0)) begin
          state_d    = ST_FETCH;
          mark_d     = rd_ptr_q;
          ack_seen_d = 1'b0;
        end
      end
      ST_FETCH: begin
        if (!blk_in_xfer_i) begin
          rd_ptr_d = mark_q;
          state_d  = ST_IDLE;
        end else begin
          ram_re    = 1'b1;
          ram_raddr = rd_ptr_q[ADDR_WIDTH-1:0];
          fa_ptr_d  = rd_ptr_q + 1'b1;
          inf_d     = 1'b1;
          state_d   = ST_STREAM;
        end
      end
      ST_STREAM: begin
        if (blk_in_ack_i) ack_seen_d = 1'b1;
        if (!blk_in_xfer_i) begin
          rd_ptr_d = mark_q;
          ov_d     = 1'b0;
          sv_d     = 1'b0;
          state_d  = ST_IDLE;
        end else if (pop && od_q[END_BIT]) begin
          // Anything prefetched past the packet end is discarded here.
          rd_ptr_d = rd_ptr_q + 1'b1;
          ov_d     = 1'b0;
          sv_d     = 1'b0;
          state_d  = ST_WAIT_HSK;
        end else begin
          if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
          if (!ov_q || pop) begin
            if (sv_q) begin
              ov_d = 1'b1;
              od_d = sd_q;
              sv_d = inf_q;
              sd_d = ram_rdata;
            end else if (inf_q) begin
              ov_d = 1'b1;
              od_d = ram_rdata;
            end else begin
              ov_d = 1'b0;
            end
          end else if (inf_q) begin
            sv_d = 1'b1;
            sd_d = ram_rdata;
          end
          if (issue) begin
            ram_re   = 1'b1;
            fa_ptr_d = fa_ptr_q + 1'b1;
            inf_d    = 1'b1;
          end
        end
      end
      ST_WAIT_HSK: begin
        if (blk_in_ack_i) ack_seen_d = 1'b1;
        if (!blk_in_xfer_i) begin
          if (ack_seen_q || blk_in_ack_i) begin
            cm_ptr_d = rd_ptr_q;
            commit   = 1'b1;
          end else begin
            rd_ptr_d = mark_q;
          end
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      wr_ptr_q   <= '0;
      seg_cnt_q  <= '0;
      rd_ptr_q   <= '0;
      cm_ptr_q   <= '0;
      fa_ptr_q   <= '0;
      mark_q     <= '0;
      pkt_cnt_q  <= '0;
      has_data_q <= 1'b0;
      xfer_q     <= 1'b0;
      ack_seen_q <= 1'b0;
      ov_q       <= 1'b0;
      sv_q       <= 1'b0;
      inf_q      <= 1'b0;
      od_q       <= '0;
      sd_q       <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      seg_cnt_q  <= seg_cnt_d;
      rd_ptr_q   <= rd_ptr_d;
      cm_ptr_q   <= cm_ptr_d;
      fa_ptr_q   <= fa_ptr_d;
      mark_q     <= mark_d;
      pkt_cnt_q  <= pkt_cnt_d;
      has_data_q <= (pkt_cnt_d != '0);
      xfer_q     <= blk_in_xfer_i;
      ack_seen_q <= ack_seen_d;
      ov_q       <= ov_d;
      sv_q       <= sv_d;
      inf_q      <= inf_d;
      od_q       <= od_d;
      sd_q       <= sd_d;
    end
  end

  assign bid_has_data_o = has_data_q;
  assign bid_tvalid_o   = ov_q;
  assign bid_tlast_o    = ov_q & od_q[END_BIT];
  assign bid_tdata_o    = od_q[7:0];
  assign level_o        = level;
  assign pkt_count_o    = pkt_cnt_q;

endmodule

// File: tb/tb_usb_bulk_in_fifo.sv
// Directed bench for usb_bulk_in_fifo: write-side vector table plus packet
// stream, replay, abort, full-buffer and reset sequences.
module tb_usb_bulk_in_fifo;
  localparam int AW  = 11;
  localparam int MPS = 512;

  logic clk = 1'b0;
  logic rst, s_tvalid, s_tready, s_tlast, xfer, ack;
  logic has_data, b_tvalid, b_tready, b_tlast;
  logic [7:0]  s_tdata, b_tdata;
  logic [AW:0] level, pkt_count;

  int checks = 0;
  int errors = 0;
  int wr_idx = 0;
  int rd_idx = 0;

  always #5 clk = ~clk;

  usb_bulk_in_fifo #(.ADDR_WIDTH(AW), .MAX_PACKET_SIZE(MPS)) dut (
    .clk(clk), .rst(rst),
    .s_tvalid_i(s_tvalid), .s_tready_o(s_tready), .s_tlast_i(s_tlast), .s_tdata_i(s_tdata),
    .blk_in_xfer_i(xfer), .blk_in_ack_i(ack),
    .bid_has_data_o(has_data), .bid_tvalid_o(b_tvalid), .bid_tready_i(b_tready),
    .bid_tlast_o(b_tlast), .bid_tdata_o(b_tdata),
    .level_o(level), .pkt_count_o(pkt_count)
  );

  typedef struct {
    bit v; bit l; int lvl; int pkt; bit rdy; bit has;
  } vec_t;

  function automatic logic [7:0] pat(input int i);
    return 8'((i * 7 + 3) & 255);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_s_tready"}, s_tready, 1);
    check({tag, "_has_data"}, has_data, 0);
    check({tag, "_tvalid"},   b_tvalid, 0);
    check({tag, "_tlast"},    b_tlast, 0);
    check({tag, "_tdata"},    b_tdata, 0);
    check({tag, "_level"},    level, 0);
    check({tag, "_pkt"},      pkt_count, 0);
  endtask

  task automatic write_frame(input int n);
    for (int i = 0; i < n; i++) begin
      int w = 0;
      s_tvalid = 1'b1;
      s_tdata  = pat(wr_idx);
      s_tlast  = (i == n - 1);
      while (!s_tready && w < 5000) begin tick; w++; end
      if (w >= 5000) begin
        check("wr_timeout", 1, 0);
        s_tvalid = 1'b0; s_tlast = 1'b0;
        return;
      end
      tick;
      wr_idx++;
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  // Streams one packet of len bytes expected at rd_idx; abort_at >= 0 drops xfer there.
  task automatic read_pkt(input int len, input bit rnd, input int abort_at);
    int k = 0, bad = 0, cyc = 0;
    bit done = 0, v, rdy;
    b_tready = 1'b0;
    xfer = 1'b1;
    tick; check("lat_e0_tvalid", b_tvalid, 0);
    tick; check("lat_e1_tvalid", b_tvalid, 0);
    tick; check("lat_e2_tvalid", b_tvalid, 1);
    while (!done && cyc < 20000) begin
      if (k == abort_at) begin
        check("abort_bytes", bad, 0);
        xfer = 1'b0; b_tready = 1'b0;
        tick;
        check("abort_tvalid", b_tvalid, 0);
        return;
      end
      rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      v = b_tvalid;
      if (!v) bad++;
      else if (b_tdata !== pat(rd_idx + k) || b_tlast !== (k == len - 1)) bad++;
      b_tready = rdy;
      tick;
      cyc++;
      if (rdy && v) begin
        if (k == len - 1) done = 1;
        k++;
      end
    end
    b_tready = 1'b0;
    check("pkt_bytes", bad, 0);
    check("pkt_len", k, len);
    check("tvalid_after_last", b_tvalid, 0);
  endtask

  task automatic finish_in(input bit do_ack, input int len);
    if (do_ack) begin
      ack = 1'b1; tick; ack = 1'b0;
      rd_idx += len;
    end
    xfer = 1'b0;
    tick;
  endtask

  vec_t tbl[7];

  initial begin
    tbl[0] = '{v:0, l:0, lvl:0, pkt:0, rdy:1, has:0};
    tbl[1] = '{v:1, l:0, lvl:1, pkt:0, rdy:1, has:0};
    tbl[2] = '{v:1, l:0, lvl:2, pkt:0, rdy:1, has:0};
    tbl[3] = '{v:0, l:0, lvl:2, pkt:0, rdy:1, has:0};
    tbl[4] = '{v:1, l:1, lvl:3, pkt:1, rdy:1, has:1};
    tbl[5] = '{v:1, l:1, lvl:4, pkt:2, rdy:1, has:1};
    tbl[6] = '{v:0, l:0, lvl:4, pkt:2, rdy:1, has:1};

    rst = 1'b1; s_tvalid = 0; s_tlast = 0; s_tdata = 0;
    xfer = 0; ack = 0; b_tready = 0;
    tick; tick;
    check_reset_vals("rst");
    rst = 1'b0;

    // Write-side vectors
    for (int i = 0; i < 7; i++) begin
      s_tvalid = tbl[i].v;
      s_tlast  = tbl[i].l;
      s_tdata  = pat(wr_idx);
      tick;
      if (tbl[i].v) wr_idx++;
      s_tvalid = 1'b0; s_tlast = 1'b0;
      check($sformatf("vec%0d_level", i), level, tbl[i].lvl);
      check($sformatf("vec%0d_pkt", i), pkt_count, tbl[i].pkt);
      check($sformatf("vec%0d_tready", i), s_tready, tbl[i].rdy);
      check($sformatf("vec%0d_has", i), has_data, tbl[i].has);
    end
    read_pkt(3, 0, -1); finish_in(1, 3);
    check("vec_rd1_pkt", pkt_count, 1); check("vec_rd1_level", level, 1);
    read_pkt(1, 0, -1); finish_in(1, 1);
    check("vec_rd2_pkt", pkt_count, 0); check("vec_rd2_level", level, 0);
    check("vec_rd2_has", has_data, 0);

    // Single short frame
    write_frame(5);
    check("short_pkt", pkt_count, 1); check("short_level", level, 5);
    read_pkt(5, 0, -1); finish_in(1, 5);
    check("short_pkt_after", pkt_count, 0); check("short_level_after", level, 0);

    // Segmentation
    write_frame(1100);
    check("seg_pkt", pkt_count, 3); check("seg_level", level, 1100);
    read_pkt(512, 0, -1); finish_in(1, 512); check("seg_level1", level, 588);
    read_pkt(512, 0, -1); finish_in(1, 512); check("seg_level2", level, 76);
    read_pkt(76, 0, -1);  finish_in(1, 76);  check("seg_level3", level, 0);
    check("seg_pkt_after", pkt_count, 0);

    // Replay: no ACK rewinds, second pass commits
    write_frame(512);
    read_pkt(512, 0, -1); finish_in(0, 512);
    check("replay_pkt", pkt_count, 1); check("replay_level", level, 512);
    read_pkt(512, 0, -1); finish_in(1, 512);
    check("replay_pkt_after", pkt_count, 0); check("replay_level_after", level, 0);

    // Abort at byte 100 under random backpressure
    write_frame(300);
    read_pkt(300, 1, 100);
    check("abort_pkt", pkt_count, 1); check("abort_level", level, 300);
    read_pkt(300, 1, -1); finish_in(1, 300);
    check("abort_pkt_after", pkt_count, 0); check("abort_level_after", level, 0);

    // Idle IN with empty buffer
    xfer = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick;
      check($sformatf("idle_tvalid%0d", i), b_tvalid, 0);
    end
    xfer = 1'b0;
    tick;
    write_frame(4);
    read_pkt(4, 0, -1); finish_in(1, 4);
    check("idle_after_level", level, 0);

    // Full buffer
    write_frame(2048);
    check("full_level", level, 2048); check("full_tready", s_tready, 0);
    check("full_pkt", pkt_count, 4);
    s_tvalid = 1'b1; s_tdata = 8'hee;
    tick;
    s_tvalid = 1'b0;
    check("full_overflow_level", level, 2048);
    read_pkt(512, 0, -1);
    check("full_pre_commit_tready", s_tready, 0);
    finish_in(1, 512);
    check("full_post_commit_tready", s_tready, 1);
    check("full_post_commit_level", level, 1536);
    check("full_post_commit_pkt", pkt_count, 3);

    // Reset mid-STREAM
    b_tready = 1'b0;
    xfer = 1'b1;
    tick; tick; tick; tick;
    check("pre_rst_tvalid", b_tvalid, 1);
    rst = 1'b1;
    tick;
    check_reset_vals("midrst");
    rst = 1'b0; xfer = 1'b0;
    tick;
    check("post_rst_pkt", pkt_count, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
